seq_chunk_adder: RTL and testbench

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder_pkg.sv | 16 +
 rtl/seq_chunk_adder_chunk_rca.sv | 30 +++
 rtl/seq_chunk_adder.sv | 114 +++++++++++
 tb/tb_seq_chunk_adder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder: FSM state encoding
// and the chunk-index width calculation.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_rca.sv
// Combinational W-bit ripple-carry adder slice; also exposes the carry into
// its top bit so the parent can form signed overflow on the final chunk.
module chunk_rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] c_s;

    // Bit-serial ripple of sum and carry through the slice.
    always_comb begin
        c_s    = '0;
        s      = '0;
        c_s[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]     = x[i] ^ y[i] ^ c_s[i];
            c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c_s[W];
    assign c_msb_in = c_s[W-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: accepts a, b, cin, then adds CHUNK bits per cycle
// through one shared ripple slice and presents sum/cout/ovf with a handshake.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    import seq_chunk_adder_pkg::*;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic [IDXW-1:0]    idx_r;
    logic               cout_r;
    logic               ovf_r;
    logic               out_valid_r;
    logic               in_ready_r;

    logic [CHUNK-1:0]   a_chunk_s;
    logic [CHUNK-1:0]   b_chunk_s;
    logic [CHUNK-1:0]   s_chunk_s;
    logic               co_s;
    logic               c_msb_s;

    assign a_chunk_s = a_r[int'(idx_r) * CHUNK +: CHUNK];
    assign b_chunk_s = b_r[int'(idx_r) * CHUNK +: CHUNK];

    chunk_rca #(.W(CHUNK)) u_rca (
        .x        (a_chunk_s),
        .y        (b_chunk_s),
        .ci       (carry_r),
        .s        (s_chunk_s),
        .co       (co_s),
        .c_msb_in (c_msb_s)
    );

    // Control FSM with operand, partial-sum and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            idx_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b;
                        carry_r    <= cin;
                        idx_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= BUSY;
                    end
                end
                BUSY: begin
                    sum_r[int'(idx_r) * CHUNK +: CHUNK] <= s_chunk_s;
                    carry_r <= co_s;
                    idx_r   <= idx_r + IDXW'(1);
                    // The last chunk's carries define the whole-word flags.
                    if (idx_r == LAST_IDX) begin
                        cout_r      <= co_s;
                        ovf_r       <= co_s ^ c_msb_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a 32/8 instance for the main function,
// handshake and reset-abort cases, and an 8/8 instance for the single-chunk case.
module tb_seq_chunk_adder;

    logic        clk;
    logic        rst;

    logic        iv0, ir0, ov0, or0, cin0, co0, of0;
    logic [31:0] a0, b0, s0;

    logic        iv1, ir1, ov1, or1, cin1, co1, of1;
    logic [7:0]  a1, b1, s1;

    int checks;
    int errors;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .cin(cin0), .out_valid(ov0), .out_ready(or0),
        .sum(s0), .cout(co0), .ovf(of0)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(ov1), .out_ready(or1),
        .sum(s1), .cout(co1), .ovf(of1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation on the 32/8 instance with out_ready held high.
    task automatic op32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        chk({tag, ".in_ready_pre"}, {31'd0, ir0}, 32'd1);
        a0 = ta; b0 = tb; cin0 = tc; iv0 = 1'b1; or0 = 1'b1;
        step();
        iv0 = 1'b0;
        lat = 0;
        while (!ov0 && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd4);
        chk({tag, ".sum"},  s0, es);
        chk({tag, ".cout"}, {31'd0, co0}, {31'd0, ec});
        chk({tag, ".ovf"},  {31'd0, of0}, {31'd0, eo});
        step();
        chk({tag, ".out_valid_post"}, {31'd0, ov0}, 32'd0);
        chk({tag, ".in_ready_post"},  {31'd0, ir0}, 32'd1);
        or0 = 1'b0;
    endtask

    initial begin
        int lat;
        int seen_valid;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        iv0 = 1'b0; or0 = 1'b0; cin0 = 1'b0; a0 = 32'd0; b0 = 32'd0;
        iv1 = 1'b0; or1 = 1'b0; cin1 = 1'b0; a1 = 8'd0;  b1 = 8'd0;
        step();
        step();
        chk("rst.in_ready",  {31'd0, ir0}, 32'd1);
        chk("rst.out_valid", {31'd0, ov0}, 32'd0);
        chk("rst.sum",       s0, 32'd0);
        chk("rst.cout",      {31'd0, co0}, 32'd0);
        chk("rst.ovf",       {31'd0, of0}, 32'd0);
        chk("rst8.in_ready", {31'd0, ir1}, 32'd1);
        chk("rst8.out_valid",{31'd0, ov1}, 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back ops also exercise the NCHUNK+2 issue interval.
        op32("small",   32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        op32("wrap",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        op32("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op32("negovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        op32("mixed",   32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0);

        // Hold in DONE with out_ready low while in_valid pulses arrive.
        a0 = 32'h1111_1111; b0 = 32'h2222_2222; cin0 = 1'b0; iv0 = 1'b1; or0 = 1'b0;
        step();
        a0 = 32'hDEAD_BEEF; b0 = 32'h0BAD_F00D; cin0 = 1'b1;
        step();
        chk("hold.in_ready_busy", {31'd0, ir0}, 32'd0);
        iv0 = 1'b0;
        lat = 0;
        while (!ov0 && lat < 20) begin
            step();
            lat++;
        end
        chk("hold.out_valid", {31'd0, ov0}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            iv0 = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
            chk("hold.valid_kept", {31'd0, ov0}, 32'd1);
            chk("hold.sum_kept",   s0, 32'h3333_3333);
            chk("hold.in_ready",   {31'd0, ir0}, 32'd0);
        end
        iv0 = 1'b0; or0 = 1'b1;
        step();
        chk("hold.release_valid", {31'd0, ov0}, 32'd0);
        chk("hold.release_ready", {31'd0, ir0}, 32'd1);
        or0 = 1'b0;
        step();
        step();
        chk("hold.no_phantom", {31'd0, ov0}, 32'd0);

        // Abort in the 2nd BUSY cycle; reset beats concurrent handshakes.
        a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0001; cin0 = 1'b0; iv0 = 1'b1;
        step();
        step();
        rst = 1'b1; or0 = 1'b1;
        step();
        chk("abort.in_ready",  {31'd0, ir0}, 32'd1);
        chk("abort.out_valid", {31'd0, ov0}, 32'd0);
        chk("abort.sum",       s0, 32'd0);
        rst = 1'b0; iv0 = 1'b0; or0 = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ov0) seen_valid = 1;
        end
        chk("abort.no_result", 32'(seen_valid), 32'd0);
        op32("after_abort", 32'd5, 32'd6, 1'b0, 32'd11, 1'b0, 1'b0);

        // Single-chunk instance: one BUSY cycle.
        a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0; iv1 = 1'b1; or1 = 1'b1;
        step();
        iv1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 20) begin
            step();
            lat++;
        end
        chk("w8.latency", 32'(lat), 32'd1);
        chk("w8.sum",  {24'd0, s1}, 32'h0000_0000);
        chk("w8.cout", {31'd0, co1}, 32'd1);
        chk("w8.ovf",  {31'd0, of1}, 32'd1);
        step();
        chk("w8.in_ready", {31'd0, ir1}, 32'd1);
        a1 = 8'h3C; b1 = 8'h0A; cin1 = 1'b1; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 20) begin
            step();
            lat++;
        end
        chk("w8b.sum",  {24'd0, s1}, 32'h0000_0047);
        chk("w8b.cout", {31'd0, co1}, 32'd0);
        chk("w8b.ovf",  {31'd0, of1}, 32'd0);
        or1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
